// File: rtl/encrypt_pkg.sv
// Shared widths, FSM state type, table write payload and the golden forward mapping.
package encrypt_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned TBL_DEPTH = 256;
   localparam logic [DATA_W-1:0] ERR_VAL = 8'hFF;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } tbl_wr_t;

   // enc(x) = x+1, with 0xFF mapped to ERR_VAL since decrypt has no preimage for it
   function automatic logic [DATA_W-1:0] enc_ref(input logic [DATA_W-1:0] x);
      return (x == 8'hFF) ? ERR_VAL : DATA_W'(x + 8'd1);
   endfunction

endpackage

// File: rtl/enc_table.sv
// 256x8 substitution RAM: one synchronous write port, one synchronous read-before-write read port.
module enc_table
   import encrypt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  tbl_wr_t           wr_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [TBL_DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_i.we) begin
         mem_q[wr_i.addr] <= wr_i.data;
      end
   end

   // Read register doubles as the stream output stage; it holds while no lookup is issued
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/encrypt_stream.sv
// Byte-stream encryptor: table load after reset, runtime re-keying, one-stage registered lookup.
module encrypt_stream #(
   parameter int unsigned DATA_W  = 8,
   parameter logic [7:0]  ERR_VAL = 8'hFF,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   input  logic              cfg_we,
   input  logic [7:0]        cfg_addr,
   input  logic [7:0]        cfg_data,
   output logic              init_done,
   output logic [CNT_W-1:0]  byte_cnt,
   output logic [CNT_W-1:0]  err_cnt
);
   import encrypt_pkg::*;

   state_e            state_q;
   logic [7:0]        idx_q;
   logic              init_done_q;
   logic              out_valid_q;
   logic              out_err_q;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              xfer;
   logic              is_err;
   tbl_wr_t           wr;

   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign xfer     = in_valid && in_ready;
   assign is_err   = (in_data == 8'hFF);

   // Table write port: the init sweep owns it until RUN, then cfg takes over
   always_comb begin
      wr = '0;
      if (state_q == ST_INIT) begin
         wr.we   = 1'b1;
         wr.addr = idx_q;
         wr.data = (idx_q == 8'hFF) ? ERR_VAL : idx_q + 8'd1;
      end else begin
         wr.we   = cfg_we;
         wr.addr = cfg_addr;
         wr.data = cfg_data;
      end
   end

   // Saturating counters
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (xfer && (byte_cnt_q != '1)) begin
         byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
      if (xfer && is_err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         byte_cnt_q  <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               idx_q <= idx_q + 8'd1;
               if (idx_q == 8'hFF) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  out_valid_q <= 1'b1;
                  out_err_q   <= is_err;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
               byte_cnt_q <= byte_cnt_d;
               err_cnt_q  <= err_cnt_d;
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   enc_table u_table (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (wr),
      .rd_en_i   (xfer),
      .rd_addr_i (in_data),
      .rd_data_o (out_data)
   );

   assign out_valid = out_valid_q;
   assign out_err   = out_err_q;
   assign init_done = init_done_q;
   assign byte_cnt  = byte_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: doc/encrypt_stream.md
Name: encrypt_stream

Overview:
Byte-stream encryptor, the transmit-side partner of the decrypt substitution table. It applies the forward table enc(x) = x+1, so that decrypt(enc(x)) = x for every x in 0..254. The table lives in a 256x8 RAM, loaded by an init FSM after reset and re-programmable at runtime. Data moves through a valid/ready stream with a one-stage registered lookup. Each output byte carries an error flag for input values that cannot be encrypted.

Parameters:
DATA_W, 8, byte width; fixed at 8 to pair with decrypt.
ERR_VAL, 8'hFF, table content and output value for input 0xFF, which has no decrypt preimage.
CNT_W, 16, width of the byte and error counters.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
in_valid  in  1  input byte valid.
in_ready  out  1  block accepts in_data this cycle.
in_data  in  8  plaintext byte.
out_valid  out  1  ciphertext byte valid.
out_ready  in  1  downstream accepts out_data.
out_data  out  8  ciphertext byte.
out_err  out  1  out_data came from unencryptable input 0xFF.
cfg_we  in  1  table write strobe.
cfg_addr  in  8  table write address.
cfg_data  in  8  table write data.
init_done  out  1  table load complete.
byte_cnt  out  CNT_W  count of accepted bytes, saturating.
err_cnt  out  CNT_W  count of accepted 0xFF bytes, saturating.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - out_valid=0, out_data=0, out_err=0, in_ready=0, init_done=0, byte_cnt=0, err_cnt=0.
  - FSM enters INIT with idx=0.
- FSM states: INIT -> RUN. There is no other exit from RUN; only reset returns the FSM to INIT.
- INIT:
  - Each cycle writes tbl[idx] = idx+1 for idx 0..254, and tbl[255] = ERR_VAL.
  - idx increments by 1 per cycle. On the write at idx=255 the FSM moves to RUN.
  - The load takes exactly 256 cycles. init_done rises, and in_ready may first be 1, on the first cycle after reset deasserts plus 256.
  - in_ready=0 throughout INIT. cfg_we is ignored in INIT.
- RUN:
  - in_ready = !out_valid || out_ready (combinational pass-through).
  - A transfer (in_valid && in_ready) reads tbl[in_data] through the synchronous RAM. out_data, out_err=(in_data==8'hFF) and out_valid=1 register on the next edge. Latency is 1 cycle.
  - Full throughput: one byte per cycle while out_ready=1.
  - Backpressure: with out_valid=1 and out_ready=0, out_data and out_err hold, in_ready=0, and no byte is lost or duplicated.
  - out_valid clears when out_ready=1 and no new transfer occurs in that cycle.
  - Simultaneous pop and push: out_valid stays 1 and the new data replaces the old.
- cfg write (RUN only):
  - tbl[cfg_addr] <= cfg_data.
  - A same-cycle lookup of the same address returns the old value (read-before-write).
  - out_err depends only on in_data==0xFF, never on table contents.
- Counters:
  - byte_cnt increments on every input transfer.
  - err_cnt increments on input transfers with in_data==0xFF.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation:
  - The pending output is dropped (out_valid=0).
  - Counters clear and the table fully reloads, discarding all cfg writes.
- Width rules: idx is 8 bits. idx+1 is computed in 8 bits, and idx=255 is special-cased to ERR_VAL.

Decomposition:
- Shared package encrypt_pkg:
  - DATA_W, TBL_DEPTH=256, ERR_VAL.
  - FSM state enum {INIT, RUN}.
  - Function enc_ref(x) giving the golden model for the bench: x+1 for x<255, else ERR_VAL.
- Sub-module enc_table:
  - 256x8 RAM, one synchronous write port, one synchronous read port, read-before-write.
  - The write port is muxed between the init FSM and cfg.

Test Plan:
- Init timing: release reset and count cycles -> init_done=1 and in_ready=1 exactly 256 cycles after reset deasserts; out_valid=0 throughout.
- Streaming, out_ready=1, inputs 0x00, 0x41, 0xFE, 0xFF back-to-back:
  - outputs one cycle later are 0x01, 0x42, 0xFF, ERR_VAL;
  - out_err is 0, 0, 0, 1;
  - byte_cnt=4, err_cnt=1.
- Backpressure: send 0x10, 0x11 with out_ready=0 for 5 cycles -> out_data holds 0x11-equivalent first result 0x11 for 0x10; in_ready=0 while held; after release 0x11 then 0x12 appear in order with no loss.
- Re-key: cfg_we addr=0x20 data=0xA5, then input 0x20 -> 0xA5. Same-cycle cfg write plus lookup of addr 0x30 -> old value 0x31.
- Reset mid-stream with out_valid=1 -> out_valid=0 next cycle, 256-cycle reload, input 0x20 -> 0x21 (cfg write discarded), counters 0.
- Round trip: all 0..254 through encrypt_stream then decrypt -> each byte reproduced exactly; 0xFF flagged by out_err.
